// File: rtl/gcd_stein_hs_if.sv
// gcd_stein_hs_if: command/result handshake bundle for the binary GCD engine.
//   start_i, a_i, b_i : command side (start request and operands)
//   ready_i           : result consumer ready
//   busy_o, valid_o   : engine status (computing / result available)
//   result_o          : GCD value, stable while valid_o is high
//   cycles_o          : busy cycles of the last or current operation
// master modport drives commands (front-end / bench); slave modport is the engine.
interface gcd_stein_hs_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic [CNT_W-1:0] cycles_o;

    modport master (
        output start_i, a_i, b_i, ready_i,
        input  busy_o, valid_o, result_o, cycles_o
    );

    modport slave (
        input  start_i, a_i, b_i, ready_i,
        output busy_o, valid_o, result_o, cycles_o
    );
endinterface

// File: rtl/gcd_stein_hs.sv
// gcd_stein_hs: Stein (binary) GCD engine, one datapath step per clock, with an
// output valid/ready handshake and a saturating busy-cycle counter.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset; aborts any operation in flight
//   bus    : gcd_stein_hs_if.slave (start_i, a_i, b_i, ready_i in;
//            busy_o, valid_o, result_o, cycles_o out)
// The interface instance must be built with the same WIDTH/CNT_W as this module.
module gcd_stein_hs #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    gcd_stein_hs_if.slave    bus
);
    localparam int K_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_STRIP_K = 3'd2,
        ST_STRIP_A = 3'd3,
        ST_LOOP    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [K_W-1:0]   k_r, k_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [CNT_W-1:0] cycles_r, cycles_s;
    logic             busy_r, busy_s;
    logic             valid_r, valid_s;
    logic [WIDTH-1:0] lo_s, hi_s, diff_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Swap-then-subtract: ordering the operands first means the subtract never underflows.
    always_comb begin
        if (a_r < b_r) begin
            lo_s = a_r;
            hi_s = b_r;
        end else begin
            lo_s = b_r;
            hi_s = a_r;
        end
        diff_s = hi_s - lo_s;
    end

    // Next-state and datapath decisions for every state.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        k_s      = k_r;
        result_s = result_r;
        cycles_s = cycles_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    a_s      = bus.a_i;
                    b_s      = bus.b_i;
                    k_s      = '0;
                    cycles_s = '0;
                    state_s  = ST_CHECK;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                cycles_s = sat_inc(cycles_r);
                if (a_r == '0) begin
                    result_s = b_r;
                    state_s  = ST_DONE;
                end else if (b_r == '0) begin
                    result_s = a_r;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_STRIP_K;
                end
            end
            ST_STRIP_K: begin
                cycles_s = sat_inc(cycles_r);
                if (!a_r[0] && !b_r[0]) begin
                    a_s = a_r >> 1;
                    b_s = b_r >> 1;
                    k_s = k_r + K_W'(1);
                end else begin
                    state_s = ST_STRIP_A;
                end
            end
            ST_STRIP_A: begin
                cycles_s = sat_inc(cycles_r);
                if (!a_r[0]) begin
                    a_s = a_r >> 1;
                end else begin
                    state_s = ST_LOOP;
                end
            end
            ST_LOOP: begin
                // a stays odd here; only b needs stripping of factors of two.
                cycles_s = sat_inc(cycles_r);
                if (!b_r[0]) begin
                    b_s = b_r >> 1;
                end else begin
                    a_s = lo_s;
                    b_s = diff_s;
                    if (diff_s == '0) begin
                        // gcd fits in WIDTH bits, so the restore shift cannot overflow.
                        result_s = lo_s << k_r;
                        state_s  = ST_DONE;
                    end else begin
                        state_s  = ST_LOOP;
                    end
                end
            end
            ST_DONE: begin
                if (bus.ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status flags decoded from the next state so the outputs come straight from flops.
    always_comb begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
        case (state_s)
            ST_CHECK, ST_STRIP_K, ST_STRIP_A, ST_LOOP: busy_s  = 1'b1;
            ST_DONE:                                  valid_s = 1'b1;
            default: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            k_r      <= '0;
            result_r <= '0;
            cycles_r <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            k_r      <= k_s;
            result_r <= result_s;
            cycles_r <= cycles_s;
            busy_r   <= busy_s;
            valid_r  <= valid_s;
        end
    end

    assign bus.busy_o   = busy_r;
    assign bus.valid_o  = valid_r;
    assign bus.result_o = result_r;
    assign bus.cycles_o = cycles_r;
endmodule

// File: tb/tb_gcd_stein_hs.sv
// tb_gcd_stein_hs: self-checking bench for gcd_stein_hs.
// u16 (WIDTH=16, CNT_W=16) runs directed cases and a random sweep, checked every
// cycle by a monitor against an Euclid-based reference model.
// u8 (WIDTH=8, CNT_W=3) covers the narrow width and counter saturation.
module tb_gcd_stein_hs;
    logic clk;
    logic rst_ni;
    int   checks;
    int   failures;

    typedef struct {
        logic [63:0] res;
        logic [63:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   lat_cnt;
    bit   lat_on;
    bit   prev_valid;

    gcd_stein_hs_if #(.WIDTH(16), .CNT_W(16)) bus16 ();
    gcd_stein_hs_if #(.WIDTH(8),  .CNT_W(3))  bus8 ();

    gcd_stein_hs #(.WIDTH(16), .CNT_W(16)) u16 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus16));
    gcd_stein_hs #(.WIDTH(8),  .CNT_W(3))  u8  (.clk_i(clk), .rst_ni(rst_ni), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: gcd by Euclid; cycle count by walking the engine's per-state step rules.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input int cw,
                                  output logic [63:0] res, output logic [63:0] cyc);
        logic [63:0] x, y, t;
        bit          fin;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        res = x;
        if (a == 0 || b == 0) begin
            cyc = 1;
        end else begin
            cyc = 1; x = a; y = b; fin = 0;
            while (x[0] == 1'b0 && y[0] == 1'b0) begin
                x = x >> 1; y = y >> 1; cyc++;
            end
            cyc++;
            while (x[0] == 1'b0) begin
                x = x >> 1; cyc++;
            end
            cyc++;
            for (int i = 0; i < 2000 && !fin; i++) begin
                cyc++;
                if (y[0] == 1'b0) begin
                    y = y >> 1;
                end else if (x > y) begin
                    t = x - y; x = y; y = t;
                end else begin
                    y = y - x;
                    if (y == 0) fin = 1;
                end
            end
        end
        if (cyc > (64'd1 << cw) - 1) cyc = (64'd1 << cw) - 1;
    endfunction

    // Per-cycle compare of u16 against the model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            exp_q.delete();
            lat_on     = 0;
            prev_valid = 0;
        end else begin
            if (lat_on) lat_cnt++;
            chk("busy", bus16.busy_o, (exp_q.size() != 0 && !bus16.valid_o));
            if (bus16.valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", bus16.valid_o, 0);
                end else begin
                    chk("mon_result", bus16.result_o, exp_q[0].res);
                    chk("mon_cycles", bus16.cycles_o, exp_q[0].cyc);
                    chk("cycles_bound", (bus16.cycles_o <= 16'd50), 1);
                    if (!prev_valid) begin
                        chk("latency", lat_cnt, exp_q[0].cyc + 1);
                        lat_on = 0;
                    end
                    if (bus16.ready_i) void'(exp_q.pop_front());
                end
            end
            prev_valid = bus16.valid_o;
            if (bus16.start_i && !bus16.busy_o && !bus16.valid_o) begin
                model({48'd0, bus16.a_i}, {48'd0, bus16.b_i}, 16, e.res, e.cyc);
                exp_q.push_back(e);
                lat_on  = 1;
                lat_cnt = 0;
            end
        end
    end

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        bus16.start_i = 1'b1; bus16.a_i = a; bus16.b_i = b;
        @(posedge clk); #1;
        bus16.start_i = 1'b0;
    endtask

    task automatic wait_valid(input string nm, output bit seen);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus16.valid_o) seen = 1;
        end
        chk({nm, "_timeout"}, seen, 1);
    endtask

    task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [63:0] er, input logic [63:0] ec, input bit use_c);
        bit seen;
        drive_start(a, b);
        wait_valid(nm, seen);
        if (seen) begin
            chk({nm, "_res"}, bus16.result_o, er);
            if (use_c) chk({nm, "_cyc"}, bus16.cycles_o, ec);
        end
    endtask

    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [63:0] er, input logic [63:0] ec);
        bit seen;
        @(posedge clk); #1;
        bus8.start_i = 1'b1; bus8.a_i = a; bus8.b_i = b;
        @(posedge clk); #1;
        bus8.start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus8.valid_o) seen = 1;
        end
        chk({nm, "_timeout"}, seen, 1);
        if (seen) begin
            chk({nm, "_res"}, bus8.result_o, er);
            chk({nm, "_cyc"}, bus8.cycles_o, ec);
        end
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'd0;
            1:       v = 16'($urandom_range(1, 255) << $urandom_range(0, 8));
            2:       v = 16'hFFFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] mr, mc;
        bit          seen;
        int          n_acc, cyc;
        checks = 0; failures = 0;
        bus16.start_i = 0; bus16.a_i = 0; bus16.b_i = 0; bus16.ready_i = 1;
        bus8.start_i  = 0; bus8.a_i  = 0; bus8.b_i  = 0; bus8.ready_i  = 1;

        // Pin the reference model with hand-computed values.
        model(64'd48, 64'd18, 16, mr, mc);
        chk("model_48_18_res", mr, 6);  chk("model_48_18_cyc", mc, 10);
        model(64'd1071, 64'd462, 16, mr, mc);
        chk("model_1071_462_res", mr, 21);
        model(64'd0, 64'd0, 16, mr, mc);
        chk("model_0_0_res", mr, 0);    chk("model_0_0_cyc", mc, 1);
        model(64'd128, 64'd64, 3, mr, mc);
        chk("model_128_64_res", mr, 64); chk("model_128_64_sat", mc, 7);

        // Reset state.
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_busy", bus16.busy_o, 0);     chk("rst_valid", bus16.valid_o, 0);
        chk("rst_result", bus16.result_o, 0); chk("rst_cycles", bus16.cycles_o, 0);
        chk("rst8_valid", bus8.valid_o, 0);   chk("rst8_cycles", bus8.cycles_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Directed main-function cases.
        do_op("g48_18", 16'd48, 16'd18, 6, 10, 1);
        chk("g48_18_busy_low", bus16.busy_o, 0);
        @(negedge clk);
        chk("g48_18_one_cycle", bus16.valid_o, 0);
        do_op("g0_7", 16'd0, 16'd7, 7, 1, 1);
        do_op("g0_0", 16'd0, 16'd0, 0, 1, 1);
        do_op("g255", 16'd255, 16'd255, 255, 4, 1);
        do_op("gffff", 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 1);
        do_op("g8000_4000", 16'h8000, 16'h4000, 16'h4000, 0, 0);
        do_op("g128_64", 16'd128, 16'd64, 64, 11, 1);
        do_op("g7_0", 16'd7, 16'd0, 7, 1, 1);

        // Narrow instance: full-scale operands and counter saturation.
        run8("w8_255", 8'd255, 8'd255, 255, 4);
        run8("w8_128_64", 8'd128, 8'd64, 64, 7);

        // Back-pressure: result held, start pulses ignored.
        bus16.ready_i = 1'b0;
        model(64'd1071, 64'd462, 16, mr, mc);
        drive_start(16'd1071, 16'd462);
        wait_valid("bp", seen);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus16.start_i = i[0]; bus16.a_i = 16'($urandom); bus16.b_i = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", bus16.valid_o, 1);
            chk("bp_res", bus16.result_o, 21);
            chk("bp_cyc", bus16.cycles_o, mc);
        end
        @(posedge clk); #1;
        bus16.start_i = 1'b0; bus16.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus16.valid_o, 1);
        @(negedge clk);
        chk("bp_drop_valid", bus16.valid_o, 0);
        chk("bp_idle_busy", bus16.busy_o, 0);
        do_op("bp_fresh", 16'd12, 16'd8, 4, 0, 0);

        // Asynchronous reset in the middle of LOOP.
        drive_start(16'd1071, 16'd462);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy_before", bus16.busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_busy", bus16.busy_o, 0);     chk("abort_valid", bus16.valid_o, 0);
        chk("abort_result", bus16.result_o, 0); chk("abort_cycles", bus16.cycles_o, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_valid", bus16.valid_o, 0);
        end
        @(posedge clk); #1 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", bus16.valid_o, 0);
        end
        do_op("after_rst", 16'd1071, 16'd462, 21, 0, 0);

        // Random sweep with back-pressure and stray start pulses.
        n_acc = 0; cyc = 0;
        while (n_acc < 1500 && cyc < 80000) begin
            @(posedge clk); #1;
            cyc++;
            bus16.ready_i = ($urandom_range(0, 3) != 0);
            bus16.a_i = rand_op();
            bus16.b_i = rand_op();
            if (!bus16.busy_o && !bus16.valid_o) begin
                bus16.start_i = ($urandom_range(0, 1) == 1);
                if (bus16.start_i) n_acc++;
            end else begin
                bus16.start_i = ($urandom_range(0, 3) == 0);
            end
        end
        chk("sweep_accepted", n_acc, 1500);
        @(posedge clk); #1;
        bus16.start_i = 1'b0; bus16.ready_i = 1'b1;
        for (int i = 0; i < 200 && (bus16.busy_o || bus16.valid_o); i++) @(negedge clk);
        @(negedge clk);
        chk("sweep_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
